// File: rtl/and_or_nand_nor3.sv
// Registered three-input AND/OR/NAND/NOR gate bank, evaluated bitwise over WIDTH lanes.
// All outputs come straight from flops, so no input reaches an output combinationally.
module and_or_nand_nor3 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g
);

    // Handshake: a/b/c are taken on any rising edge with in_valid=1 (no backpressure);
    // out_valid is high for exactly the following cycle, and d/e/f/g hold otherwise.
    logic [WIDTH-1:0] and_next;
    logic [WIDTH-1:0] or_next;

    always_comb begin
        and_next = a & b & c;
        or_next  = a | b | c;
    end

    // NAND/NOR get their own flops so every output is a direct register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            e         <= '0;
            f         <= '1;
            g         <= '1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d <= and_next;
                e <= or_next;
                f <= ~and_next;
                g <= ~or_next;
            end
        end
    end

endmodule

// File: tb/tb_and_or_nand_nor3.sv
// Scoreboard bench for and_or_nand_nor3: a 4-lane and a 1-lane instance share stimulus,
// the 1-lane copy sees lane 0. Expected {d,e,f,g} words are queued by the driver.
module tb_and_or_nand_nor3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] c = '0;

    logic       out_valid4, out_valid1;
    logic [3:0] d4, e4, f4, g4;
    logic       d1, e1, f1, g1;

    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h00FF;
    int          checks = 0;
    int          passed = 0;
    bit          started = 1'b0;
    bit          done = 1'b0;

    always #5 clk = ~clk;

    and_or_nand_nor3 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .out_valid(out_valid4), .d(d4), .e(e4), .f(f4), .g(g4)
    );

    and_or_nand_nor3 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0]), .b(b[0]), .c(c[0]),
        .out_valid(out_valid1), .d(d1), .e(e1), .f(f1), .g(g1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle; an accepted sample pushes its expected {d,e,f,g} word.
    task automatic drive(input logic r, input logic v, input logic [3:0] av,
                         input logic [3:0] bv, input logic [3:0] cv, input logic [15:0] exp);
        @(negedge clk);
        rst = r;
        in_valid = v;
        a = av;
        b = bv;
        c = cv;
        if (v && !r) exp_q.push_back(exp);
    endtask

    // Directed send with hand-computed single-lane results replicated over all lanes.
    task automatic send_bit(input logic [2:0] abc, input logic dv, input logic ev,
                            input logic fv, input logic gv);
        drive(1'b0, 1'b1, {4{abc[2]}}, {4{abc[1]}}, {4{abc[0]}},
              {{4{dv}}, {4{ev}}, {4{fv}}, {4{gv}}});
    endtask

    // Monitor: samples control at the edge, checks outputs 1 ns later.
    initial begin : monitor
        logic r, v;
        logic [15:0] exp;
        forever begin
            @(posedge clk);
            r = rst;
            v = in_valid;
            #1;
            if (r) begin
                started = 1'b1;
                last_exp = 16'h00FF;
                chk("reset_vals4", {d4, e4, f4, g4}, last_exp);
                chk("reset_valid", {14'd0, out_valid4, out_valid1}, 16'd0);
            end else if (started) begin
                chk("out_valid", {14'd0, out_valid4, out_valid1}, {14'd0, v, v});
                if (out_valid4) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 16'd1, 16'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        last_exp = exp;
                        chk("result4", {d4, e4, f4, g4}, exp);
                    end
                end else begin
                    chk("hold4", {d4, e4, f4, g4}, last_exp);
                end
                chk("lane1", {12'd0, d1, e1, f1, g1},
                    {12'd0, last_exp[12], last_exp[8], last_exp[4], last_exp[0]});
                chk("invariants", {f4, g4, d4 & ~e4, 3'd0, f1 ^ d1},
                    {~d4, ~e4, 4'd0, 3'd0, 1'b1});
            end
            if (done) break;
        end
    end

    // Hand-computed truth table rows: {abc, d, e, f, g}
    logic [6:0] tt [8] = '{
        7'b000_0011, 7'b001_0110, 7'b010_0110, 7'b011_0110,
        7'b100_0110, 7'b101_0110, 7'b110_0110, 7'b111_1100
    };

    initial begin : driver
        logic [3:0] ra, rb, rc;
        logic       rv;
        // Reset for two cycles with random valid inputs.
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 16'h0);
        // Back-to-back truth table.
        for (int i = 0; i < 8; i++)
            send_bit(tt[i][6:4], tt[i][3], tt[i][2], tt[i][1], tt[i][0]);
        // Hold: load 111, then three idle cycles with zero inputs.
        send_bit(3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0);
        // Multi-lane vector.
        drive(1'b0, 1'b1, 4'b1100, 4'b1010, 4'b1001, {4'b1000, 4'b1111, 4'b0111, 4'b0000});
        // Reset mid-stream discards the in-flight 011 sample.
        send_bit(3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h0, 4'hF, 4'hF, 16'h0);
        send_bit(3'b011, 1'b0, 1'b1, 1'b1, 1'b0);
        // Random regression against a simple reference expression.
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            rv = 1'($urandom_range(0, 1));
            drive(1'b0, rv, ra, rb, rc, {ra & rb & rc, ra | rb | rc, ~(ra & rb & rc), ~(ra | rb | rc)});
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0);
        done = 1'b1;
        @(posedge clk);
        #2;
        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
